// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy level, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky error
// flags and a choice of first-word-fall-through or registered read port.
module sync_fifo_flags #(
    parameter int BITS       = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int WORD_DEPTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  write,
    input  logic [BITS-1:0]       data_in,
    input  logic                  read,
    output logic [BITS-1:0]       data_out,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow_err,
    output logic                  underflow_err,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    // WORD_DEPTH survives only for drop-in compatibility; it must agree
    // with the depth implied by ADDR_WIDTH, and the thresholds must be in range.
    if (WORD_DEPTH != DEPTH || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_err
        $error("sync_fifo_flags: inconsistent depth or threshold parameters");
    end

    logic [BITS-1:0]     mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] level_q;
    logic [BITS-1:0]     head;
    logic                rd_ok;
    logic                wr_ok;
    logic                ovf_set;
    logic                udf_set;
    logic                ovf_q;
    logic                udf_q;

    // Handshake: a pop is taken whenever read is high and the FIFO holds a
    // word (rd_ok); a push is taken whenever write is high and there is room,
    // where a same-cycle pop frees room on a full FIFO (wr_ok). A push and pop
    // on an empty FIFO never bypass: the push lands, the pop is refused.
    // Flush swallows both requests and raises no error for them.
    assign ready        = (level_q != '0);
    assign full         = (level_q == FULL_LVL);
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign level        = level_q;

    assign rd_ok   = read & ready;
    assign wr_ok   = write & (~full | rd_ok);
    assign ovf_set = ~flush & write & ~wr_ok;
    assign udf_set = ~flush & read & ~ready;
    assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

    // Storage write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_ok) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointers (with wrap bit) and the occupancy counter.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)      level_q <= level_q + 1'b1;
            else if (rd_ok && !wr_ok) level_q <= level_q - 1'b1;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (udf_set)      udf_q <= 1'b1;
            else if (err_clr) udf_q <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; zeroed while empty.
        always_comb begin
            data_out   = ready ? head : '0;
            data_valid = ready;
        end
    end else begin : g_reg_read
        logic [BITS-1:0] dout_q;
        logic            dvalid_q;

        // Registered read: capture the head on each pop, pulse valid once.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else if (flush) begin
                dvalid_q <= 1'b0;
            end else begin
                dvalid_q <= rd_ok;
                if (rd_ok) dout_q <= head;
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dvalid_q;
    end

endmodule
